// File: rtl/spmv_mem_arbiter.sv
// spmv_mem_arbiter: shares the single PE memory port among N_REQ stream
// fetchers. Round-robin grant, tag = requester index, responses routed back
// by tag, and per-requester load credits so every response has a consumer.
// Optional build macro SPMV_ARB_PERF_EN adds grant/stall performance counters.
module spmv_mem_arbiter #(
    parameter int N_REQ           = 6,
    parameter int MAX_OUTSTANDING = 16,
    parameter int ADDR_W          = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_ld,
    input  logic [N_REQ-1:0]        req_st,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*64-1:0]     req_d,
    output logic [N_REQ-1:0]        req_grant,
    output logic                    req_mem_ld,
    output logic                    req_mem_st,
    output logic [ADDR_W-1:0]       req_mem_addr,
    output logic [63:0]             req_mem_d_or_tag,
    input  logic                    req_mem_stall,
    input  logic                    rsp_mem_push,
    input  logic [2:0]              rsp_mem_tag,
    input  logic [63:0]             rsp_mem_q,
    output logic                    rsp_mem_stall,
    output logic [N_REQ-1:0]        rsp_push,
    output logic [63:0]             rsp_q,
    input  logic [N_REQ-1:0]        rsp_stall,
    output logic                    outstanding_err,
    output logic                    busy
);

    // Counter must be able to hold MAX_OUTSTANDING itself, hence the extra bit.
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [2:0]        ptr_reg, ptr_next;
    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  load_full;
    logic [N_REQ-1:0]  cnt_nz;
    logic [N_REQ-1:0]  rsp_hit;
    logic [N_REQ-1:0]  rsp_ok;
    logic [N_REQ-1:0]  grant_vec;
    logic              grant_any;
    logic [2:0]        grant_idx;
    logic              grant_ld;
    logic              grant_st;
    logic [ADDR_W-1:0] grant_addr;
    logic [63:0]       grant_st_d;
    logic              rsp_err;

    logic [CNT_W-1:0]  cnt_reg [N_REQ];

    logic              req_mem_ld_reg;
    logic              req_mem_st_reg;
    logic [ADDR_W-1:0] req_mem_addr_reg;
    logic [63:0]       req_mem_d_reg;
    logic              rsp_mem_stall_reg;
    logic [N_REQ-1:0]  rsp_push_reg;
    logic [63:0]       rsp_q_reg;
    logic              err_reg;

    // Per-requester eligibility, response decode and credit counters.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        logic inc;
        logic dec;

        assign load_full[gi] = (cnt_reg[gi] == CNT_W'(MAX_OUTSTANDING));
        assign cnt_nz[gi]    = (cnt_reg[gi] != '0);
        // Reset gating keeps req_grant at 0 while rst is held.
        assign elig[gi]      = !rst && !req_mem_stall &&
                               (req_st[gi] || (req_ld[gi] && !load_full[gi]));
        assign rsp_hit[gi]   = rsp_mem_push && (rsp_mem_tag == 3'(gi));
        assign rsp_ok[gi]    = rsp_hit[gi] && cnt_nz[gi];
        assign inc           = grant_vec[gi] && req_ld[gi] && !req_st[gi];
        assign dec           = rsp_ok[gi];

        // Credit counter: +1 on load grant, -1 on accepted response, both cancel.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg[gi] <= '0;
            end else if (inc && !dec) begin
                cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_reg[gi] <= cnt_reg[gi] - CNT_W'(1);
            end
        end
    end

    // Round-robin search starting at ptr_reg, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        grant_vec = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!grant_any && (i == idx) && elig[i]) begin
                    grant_any    = 1'b1;
                    grant_idx    = 3'(i);
                    grant_vec[i] = 1'b1;
                end
            end
        end
    end

    // Select the winning request's operation, address and store data.
    always_comb begin
        grant_ld   = 1'b0;
        grant_st   = 1'b0;
        grant_addr = '0;
        grant_st_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_vec[i]) begin
                grant_ld   = req_ld[i] && !req_st[i];
                grant_st   = req_st[i];
                grant_addr = req_addr[i*ADDR_W +: ADDR_W];
                grant_st_d = req_d[i*64 +: 64];
            end
        end
    end

    // Next pointer is one past the winner; unchanged when idle.
    always_comb begin
        ptr_next = ptr_reg;
        if (grant_any) begin
            ptr_next = (grant_idx == 3'(N_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    // A push that matches no requester with outstanding credit is a protocol error.
    assign rsp_err = rsp_mem_push && !(|rsp_ok);

    // Pointer, issue register, response register and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg           <= '0;
            req_mem_ld_reg    <= 1'b0;
            req_mem_st_reg    <= 1'b0;
            req_mem_addr_reg  <= '0;
            req_mem_d_reg     <= '0;
            rsp_mem_stall_reg <= 1'b0;
            rsp_push_reg      <= '0;
            rsp_q_reg         <= '0;
            err_reg           <= 1'b0;
        end else begin
            ptr_reg           <= ptr_next;
            req_mem_ld_reg    <= grant_any && grant_ld;
            req_mem_st_reg    <= grant_any && grant_st;
            if (grant_any) begin
                req_mem_addr_reg <= grant_addr;
                req_mem_d_reg    <= grant_st ? grant_st_d : {61'b0, grant_idx};
            end
            rsp_mem_stall_reg <= |rsp_stall;
            rsp_push_reg      <= rsp_ok;
            if (|rsp_ok) begin
                rsp_q_reg <= rsp_mem_q;
            end
            if (rsp_err) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign req_grant        = grant_vec;
    assign req_mem_ld       = req_mem_ld_reg;
    assign req_mem_st       = req_mem_st_reg;
    assign req_mem_addr     = req_mem_addr_reg;
    assign req_mem_d_or_tag = req_mem_d_reg;
    assign rsp_mem_stall    = rsp_mem_stall_reg;
    assign rsp_push         = rsp_push_reg;
    assign rsp_q            = rsp_q_reg;
    assign outstanding_err  = err_reg;
    assign busy             = (|cnt_nz) || req_mem_ld_reg || req_mem_st_reg;

`ifdef SPMV_ARB_PERF_EN
    logic [31:0] grant_count [N_REQ];
    logic [31:0] stall_count;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf
        // Per-requester grant counter, wraps naturally at 2^32.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                grant_count[gi] <= '0;
            end else if (grant_vec[gi]) begin
                grant_count[gi] <= grant_count[gi] + 32'd1;
            end
        end
    end

    // Cycles where some request is pending but the memory port is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (req_mem_stall && (|(req_ld | req_st))) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/spmv_mem_arbiter.md
Name: spmv_mem_arbiter

Overview:
- Shares the single PE main-memory port (req_mem_* / rsp_mem_*) among up to 8 stream fetchers inside spmv_pe: spm code, spm argument, fzip code and fzip argument streams, x-vector loads and y-vector stores.
- Round-robin arbitration onto the request port.
- The 3-bit memory tag carries the requester index, and each response is routed back to its requester by tag.
- Per-requester outstanding-load credit counters ensure every returned response has a consumer slot.

Parameters:
N_REQ, 6, number of requesters (2..8); requester i uses tag i
MAX_OUTSTANDING, 16, maximum in-flight loads per requester (power of 2, 2..256)
ADDR_W, 48, memory address width

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
req_ld  input  N_REQ  per-requester load request
req_st  input  N_REQ  per-requester store request (ld and st must not both be high for one requester)
req_addr  input  N_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
req_d  input  N_REQ*64  packed store data
req_grant  output  N_REQ  one-hot, combinational; request accepted this cycle
req_mem_ld  output  1  registered load to memory
req_mem_st  output  1  registered store to memory
req_mem_addr  output  ADDR_W  registered address
req_mem_d_or_tag  output  64  store data, or the tag zero-extended for loads
req_mem_stall  input  1  memory port back-pressure
rsp_mem_push  input  1  memory response valid
rsp_mem_tag  input  3  response tag
rsp_mem_q  input  64  response data
rsp_mem_stall  output  1  registered back-pressure to memory
rsp_push  output  N_REQ  registered one-hot response strobe
rsp_q  output  64  registered response data, shared by all requesters
rsp_stall  input  N_REQ  per-consumer back-pressure
outstanding_err  output  1  sticky protocol-error flag
busy  output  1  any load outstanding, or request register occupied

Behaviour:
- Reset (async, rst high): all outputs 0, round-robin pointer 0, all credit counters 0, outstanding_err 0.
- Eligibility:
  - Requester i is eligible when req_ld[i] or req_st[i] is high, req_mem_stall is 0, and the request is not blocked by credits.
  - A load from requester i is blocked when cnt[i] == MAX_OUTSTANDING. Stores are never blocked by credits.
- Arbitration:
  - Search starts at index ptr and wraps modulo N_REQ. The first eligible requester w gets req_grant[w] in the same cycle.
  - ptr <= (w+1) mod N_REQ after each grant; ptr is unchanged when nothing is granted.
  - At most one grant per cycle; no grant while req_mem_stall is high.
- Issue, one cycle after the grant:
  - req_mem_ld/st, req_mem_addr and req_mem_d_or_tag hold the granted request.
  - For loads, req_mem_d_or_tag = {61'b0, w[2:0]}.
  - With no grant, ld and st are 0; addr and data hold their previous values.
- Credits:
  - cnt[w] increments on a load grant.
  - cnt[rsp_mem_tag] decrements on rsp_mem_push.
  - A grant and a response for the same requester in the same cycle leave cnt unchanged.
- Response routing:
  - rsp_mem_push with tag t, where t < N_REQ, gives rsp_push[t]=1 and rsp_q=rsp_mem_q in the next cycle.
  - Latency is 1 cycle; there is no buffering.
- rsp_mem_stall <= |rsp_stall (registered).
- Error detection:
  - A response with tag >= N_REQ, or with cnt[tag]==0, sets outstanding_err, which stays set until rst.
  - That response is dropped: no rsp_push, and the counter is not decremented.
- busy = (any cnt != 0) | req_mem_ld | req_mem_st.
- If rst asserts mid-operation, in-flight responses arriving afterwards hit cnt==0 and set outstanding_err. The controller must drain (wait for !busy) before issuing OP_RST.

Optional Feature:
- Macro: SPMV_ARB_PERF_EN.
- Defined:
  - Adds 32-bit counters grant_count[i] (one per requester) and stall_count (cycles with any request pending while req_mem_stall=1).
  - grant_count[i] wraps at 2^32.
  - Counters clear on rst and are readable hierarchically by the bench.
- Undefined: the counters and their logic are absent, with no port change.

Test Plan (all with N_REQ=4, MAX_OUTSTANDING=4):
- Round-robin fairness:
  - Stimulus: req_ld=4'b1111 held for 8 cycles, memory latency 10 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3; req_mem_d_or_tag tags 0,1,2,3,... one cycle after each grant.
- Credit limit:
  - Stimulus: only requester 2 requests; no responses for 20 cycles.
  - Required: exactly 4 grants, then req_grant=0.
  - Stimulus: one response with tag 2.
  - Required: rsp_push=4'b0100 one cycle later and one further grant.
- Stall:
  - Stimulus: req_mem_stall=1 for 5 cycles while req_st[1]=1, addr=0x1000, d=0xDEAD.
  - Required: no grant and req_mem_st=0 during the stall; the grant follows the first unstalled cycle, then req_mem_st=1, addr=0x1000, d_or_tag=0xDEAD.
- Simultaneous grant and response on requester 0 with cnt[0]=4:
  - Stimulus: the response arrives in the same cycle as a pending ld.
  - Required: the ld is blocked that cycle (cnt is evaluated before the decrement) and granted the next cycle; cnt then reads 4.
- Protocol error:
  - Stimulus: a response with tag 5, then a response with tag 1 while cnt[1]=0.
  - Required: outstanding_err=1 after the first response, no rsp_push for either, and it stays 1 until rst.
- Async reset:
  - Stimulus: assert rst mid-cycle with 3 loads outstanding.
  - Required: all outputs 0 immediately, busy=0, ptr restarts at 0.
